// File: rtl/edge_det_pkg.sv
// -----------------------------------------------------------------------------
// edge_det_pkg
// Shared definitions for the multi-channel edge detector:
//   - mode_e          : per-channel edge selection encoding
//   - DEF_*           : default synchroniser depth and debounce length
//   - mode_allows()   : whether a mode reports a rising or a falling toggle
// -----------------------------------------------------------------------------
package edge_det_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 3;

  // True when a toggle in the given direction should produce a pulse.
  function automatic logic mode_allows(input logic [1:0] mode, input logic rising);
    if (rising) begin
      return (mode == MODE_RISE) || (mode == MODE_BOTH);
    end
    return (mode == MODE_FALL) || (mode == MODE_BOTH);
  endfunction

endpackage

// File: rtl/edge_detector_multi_if.sv
// -----------------------------------------------------------------------------
// edge_detector_multi_if
// Bundles the per-channel inputs and outputs of edge_detector_multi.
//   iSig    raw asynchronous inputs                 (master -> slave)
//   iMode   2 bits per channel, [2c+1:2c]           (master -> slave)
//   iClear  level-sensitive sticky clear            (master -> slave)
//   oLevel  debounced level                         (slave -> master)
//   oPulse  one-cycle edge pulse                    (slave -> master)
//   oSticky latched event flags                     (slave -> master)
//   oAny    OR of oSticky                           (slave -> master)
// There is no valid/ready handshake: every signal is a plain level sampled
// or updated on each iClk edge.
// -----------------------------------------------------------------------------
interface edge_detector_multi_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   iSig;
  logic [2*NUM_CH-1:0] iMode;
  logic [NUM_CH-1:0]   iClear;
  logic [NUM_CH-1:0]   oLevel;
  logic [NUM_CH-1:0]   oPulse;
  logic [NUM_CH-1:0]   oSticky;
  logic                oAny;

  modport master (
    output iSig, iMode, iClear,
    input  oLevel, oPulse, oSticky, oAny
  );

  modport slave (
    input  iSig, iMode, iClear,
    output oLevel, oPulse, oSticky, oAny
  );
endinterface

// File: rtl/edge_det_channel.sv
// -----------------------------------------------------------------------------
// edge_det_channel
// One channel: synchroniser chain, debounce counter, edge pulse, sticky flag.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_sig          raw asynchronous input
//   i_mode         edge selection (mode_e encoding)
//   i_clear        sticky clear, level-sensitive
//   o_level        debounced level
//   o_pulse        registered one-cycle pulse on an enabled toggle
//   o_sticky       latched event flag
//   o_sticky_nxt   next-state sticky, used by the top for the aligned OR
// -----------------------------------------------------------------------------
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 8,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sig,
  input  logic [1:0] i_mode,
  input  logic       i_clear,
  output logic       o_level,
  output logic       o_pulse,
  output logic       o_sticky,
  output logic       o_sticky_nxt
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_pulse;
  logic                   r_sticky;

  logic w_s;
  logic w_diff;
  logic w_accept;
  logic w_pulse_nxt;
  logic w_sticky_nxt;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_diff   = (w_s != r_level);
  // The counter only climbs while the level disagrees, so it stops at
  // LP_CNT_LAST and cannot wrap.
  assign w_accept = w_diff && (r_cnt == LP_CNT_LAST);

  // Mode is looked at only on the accepting edge.
  assign w_pulse_nxt  = w_accept && mode_allows(i_mode, w_s);
  // Set has priority over clear.
  assign w_sticky_nxt = w_pulse_nxt || (r_sticky && !i_clear);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync   <= {SYNC_STAGES{RESET_LEVEL}};
      r_cnt    <= '0;
      r_level  <= RESET_LEVEL;
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_pulse  <= w_pulse_nxt;
      r_sticky <= w_sticky_nxt;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level      = r_level;
  assign o_pulse      = r_pulse;
  assign o_sticky     = r_sticky;
  assign o_sticky_nxt = w_sticky_nxt;

endmodule

// File: rtl/edge_detector_multi.sv
// -----------------------------------------------------------------------------
// edge_detector_multi
// NUM_CH independent edge-detector channels plus a shared "any event" flag.
// Ports:
//   iClk  system clock
//   iRst  asynchronous active-high reset
//   bus   edge_detector_multi_if.slave: iSig, iMode, iClear in;
//         oLevel, oPulse, oSticky, oAny out
// -----------------------------------------------------------------------------
module edge_detector_multi
  import edge_det_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 8,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input logic                  iClk,
  input logic                  iRst,
  edge_detector_multi_if.slave bus
);

  logic [NUM_CH-1:0] w_level;
  logic [NUM_CH-1:0] w_pulse;
  logic [NUM_CH-1:0] w_sticky;
  logic [NUM_CH-1:0] w_sticky_nxt;
  logic              r_any;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_ch (
      .i_clk        (iClk),
      .i_rst        (iRst),
      .i_sig        (bus.iSig[c]),
      .i_mode       (bus.iMode[2*c +: 2]),
      .i_clear      (bus.iClear[c]),
      .o_level      (w_level[c]),
      .o_pulse      (w_pulse[c]),
      .o_sticky     (w_sticky[c]),
      .o_sticky_nxt (w_sticky_nxt[c])
    );
  end

  // OR of the next-state flags keeps oAny on the same cycle as oSticky.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_sticky_nxt;
    end
  end

  assign bus.oLevel  = w_level;
  assign bus.oPulse  = w_pulse;
  assign bus.oSticky = w_sticky;
  assign bus.oAny    = r_any;

endmodule
